// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch stage with prefetch FIFO and redirect flush
//
// Owns the fetch PC, issues one word read at a time to instruction memory
// over a req/ack handshake, queues returned words with their PCs, and
// presents the queue head to the datapath. A redirect flushes queued words
// and discards any fetch still in flight.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high
//   imem_req     out  1   fetch request, held until imem_ack
//   imem_addr    out  32  word address of the request, stable while imem_req=1
//   imem_ack     in   1   memory accepts the request and returns data this cycle
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   redirect     in   1   flush and restart fetch at redirect_pc
//   redirect_pc  in   32  new fetch PC, bits [1:0] forced to 00
//   instr_valid  out  1   FIFO head valid
//   instr        out  32  FIFO head instruction
//   instr_pc     out  32  PC of the FIFO head
//   instr_ready  in   1   consumer takes the head this cycle
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fpc_q, fpc_d;
    logic [31:0]        pend_q, pend_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        instr_mem_q [DEPTH];
    logic [31:0]        pc_mem_q    [DEPTH];

    logic [31:0]        target;
    logic               pop;
    logic               fire;
    logic               push;
    logic [CNT_W-1:0]   count_after_push;

    assign imem_req    = (state_q != S_IDLE);
    assign imem_addr   = fpc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];

    assign target = redirect_pc & 32'hFFFF_FFFC;
    assign fire   = imem_req & imem_ack;
    // A pop coinciding with a redirect is void: the flush wins.
    assign pop    = instr_valid & instr_ready & ~redirect;

    // Occupancy after this cycle's push, used to decide whether another
    // slot can be reserved for a back-to-back request.
    assign count_after_push = count_q + ONE_C - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        pend_d  = pend_q;
        push    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fpc_d = target;
                end else if (count_q < DEPTH_C) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (redirect) begin
                    if (fire) begin
                        fpc_d   = target;
                        state_d = S_IDLE;
                    end else begin
                        // imem_addr must not move while the request is
                        // outstanding, so park the target until the ack.
                        pend_d  = target;
                        state_d = S_KILL;
                    end
                end else if (fire) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + 32'd4;
                    if (count_after_push >= DEPTH_C) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_KILL: begin
                if (fire) begin
                    fpc_d   = redirect ? target : pend_q;
                    state_d = S_IDLE;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fpc_q    <= RESET_PC;
            pend_q   <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            pend_q   <= pend_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= imem_rdata;
                pc_mem_q[wr_ptr_q]    <= fpc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - scoreboard bench for fetch_buffer
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    bit          stale = 1'b0;
    bit          prev_req = 1'b0;
    bit          prev_fire = 1'b0;
    logic [31:0] prev_addr = '0;
    int          idle_run = 0;
    int          n_popped = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    bit          drv_en = 1'b0;
    int          p_ack = 0;
    int          p_ready = 0;
    int          p_redir = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc  = RESET_PC;
        stale     = 1'b0;
        prev_req  = 1'b0;
        prev_fire = 1'b0;
        idle_run  = 0;
    endtask

    task automatic check_reset_outputs();
        check1("rst_imem_req", imem_req, 1'b0);
        check32("rst_imem_addr", imem_addr, RESET_PC);
        check1("rst_instr_valid", instr_valid, 1'b0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_instr_pc", instr_pc, 32'h0);
    endtask

    // Stimulus: memory responder, consumer and redirect source.
    always @(posedge clk) begin
        #1;
        if (!drv_en || reset) begin
            imem_ack    = 1'b0;
            imem_rdata  = '0;
            instr_ready = 1'b0;
            redirect    = 1'b0;
            redirect_pc = '0;
        end else begin
            imem_ack    = imem_req && ($urandom_range(99) < p_ack);
            imem_rdata  = $urandom;
            instr_ready = ($urandom_range(99) < p_ready);
            redirect    = ($urandom_range(99) < p_redir);
            if ($urandom_range(3) == 0) begin
                redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            end else begin
                redirect_pc = $urandom;
            end
        end
    end

    // Monitor: compares the presented head against the scoreboard.
    always @(negedge clk) begin
        entry_t e;
        if (!reset && chk_en) begin
            check1("instr_valid", instr_valid, exp_q.size() != 0);
            if (exp_q.size() >= DEPTH) begin
                check1("req_when_full", imem_req, 1'b0);
            end
            if (imem_req || redirect || exp_q.size() >= DEPTH) begin
                idle_run = 0;
            end else begin
                idle_run++;
                if (idle_run >= 3) begin
                    check1("req_with_free_slot", imem_req, 1'b1);
                    idle_run = 0;
                end
            end
            if (instr_valid && instr_ready && !redirect && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("instr_pc", instr_pc, e.pc);
                check32("instr", instr, e.data);
                n_popped++;
            end
        end
    end

    // Reference model: a word is delivered iff it is acked without a redirect
    // and its request was not outstanding across an earlier redirect.
    always @(negedge clk) begin
        logic   fire;
        entry_t e;
        #1;
        if (!reset && chk_en) begin
            fire = imem_req && imem_ack;
            if (imem_req && !stale) begin
                check32("imem_addr", imem_addr, model_pc);
            end
            if (prev_req && !prev_fire) begin
                check1("req_held", imem_req, 1'b1);
                check32("addr_stable", imem_addr, prev_addr);
            end
            if (redirect) begin
                exp_q.delete();
            end else if (fire && !stale) begin
                e.pc   = model_pc;
                e.data = imem_rdata;
                exp_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
            if (redirect) begin
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            if (fire) begin
                stale = 1'b0;
            end else if (redirect && imem_req) begin
                stale = 1'b1;
            end
            prev_req  = imem_req;
            prev_addr = imem_addr;
            prev_fire = fire;
        end
    end

    task automatic run_phase(input int a, input int r, input int d, input int n);
        p_ack   = a;
        p_ready = r;
        p_redir = d;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        #2;
        model_reset();
        p_ack   = 100;
        p_ready = 100;
        p_redir = 0;
        reset   = 1'b0;
        drv_en  = 1'b1;
        chk_en  = 1'b1;
        @(negedge clk);
        check1("first_req_latency", imem_req, 1'b1);
        check32("first_req_addr", imem_addr, RESET_PC);

        run_phase(100, 100, 0, 20);
        run_phase(100, 0, 0, 12);
        run_phase(100, 50, 0, 20);
        run_phase(25, 70, 0, 100);
        run_phase(40, 60, 15, 400);
        run_phase(90, 90, 20, 300);
        for (int b = 0; b < 10; b++) begin
            run_phase($urandom_range(10, 100), $urandom_range(0, 100), $urandom_range(0, 25), 50);
        end

        // Asynchronous reset in the middle of a streaming burst.
        run_phase(100, 100, 0, 10);
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check1("post_reset_req", imem_req, 1'b1);
        check32("post_reset_addr", imem_addr, RESET_PC);
        run_phase(100, 100, 0, 30);
        run_phase(50, 50, 10, 100);

        n_vec++;
        if (n_popped < 100) begin
            n_bad++;
            $display("FAIL throughput: got %0d delivered words, expected at least 100", n_popped);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
